// File: rtl/fifo_frame_parser_16.sv
// fifo_frame_parser_16
//
// Reads 16-bit words from a prefetch FIFO read port. It hunts for SYNC_WORD,
// reads a payload length, forwards the payload as a framed stream, and then
// compares a trailing additive checksum. The checksum result is reported with
// pulses and wrapping counters.
//
// Handshakes (both sides use valid/ready):
//   input  : a word is consumed on a rising edge when in_vld & in_rd.
//   output : a word is transferred on a rising edge when out_vld & out_rdy.
//            out_data/out_sop/out_eop are held stable while out_vld & ~out_rdy.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   in_data, in_vld      FIFO read data and its valid flag
//   in_rd                FIFO read enable (combinational, gated by rst)
//   out_data, out_vld    payload word and its valid flag
//   out_sop, out_eop     first/last payload word markers, qualified by out_vld
//   out_rdy              downstream ready
//   frame_ok             one-cycle pulse: checksum matched
//   csum_err             one-cycle pulse: checksum mismatched
//   len_err              one-cycle pulse: length was 0 or above MAX_LEN
//   frame_cnt, err_cnt   wrapping counts of good frames and error events
//   dbg_state            current parser state (HUNT=0, LEN=1, PAYLOAD=2, CSUM=3)

module fifo_frame_parser_16 #(
    parameter logic [15:0] SYNC_WORD = 16'hEB90,
    parameter int          MAX_LEN   = 1024,
    parameter int          LEN_W     = 11,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      in_data,
    input  logic             in_vld,
    output logic             in_rd,
    output logic [15:0]      out_data,
    output logic             out_vld,
    output logic             out_sop,
    output logic             out_eop,
    input  logic             out_rdy,
    output logic             frame_ok,
    output logic             csum_err,
    output logic             len_err,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        S_HUNT    = 2'd0,
        S_LEN     = 2'd1,
        S_PAYLOAD = 2'd2,
        S_CSUM    = 2'd3
    } state_t;

    localparam logic [15:0] MAX_LEN_16 = 16'(MAX_LEN);

    state_t             r_state;
    state_t             w_next_state;
    logic [LEN_W-1:0]   r_remaining;
    logic [15:0]        r_sum;
    logic               r_first;
    logic [15:0]        r_out_data;
    logic               r_out_vld;
    logic               r_out_sop;
    logic               r_out_eop;
    logic               r_frame_ok;
    logic               r_csum_err;
    logic               r_len_err;
    logic [CNT_W-1:0]   r_frame_cnt;
    logic [CNT_W-1:0]   r_err_cnt;

    logic               w_rd;
    logic               w_take;
    logic               w_len_ok;
    logic               w_load;

    assign w_take   = in_vld & w_rd;
    assign w_len_ok = (in_data != 16'd0) && (in_data <= MAX_LEN_16);
    assign w_load   = (r_state == S_PAYLOAD) & w_take;

    // Next state and read enable. in_rd never depends on in_vld, so the FIFO
    // sees no combinational loop through this block.
    always_comb begin
        w_next_state = r_state;
        w_rd         = 1'b1;
        case (r_state)
            S_HUNT: begin
                if (w_take && (in_data == SYNC_WORD)) w_next_state = S_LEN;
            end
            S_LEN: begin
                if (w_take) w_next_state = w_len_ok ? S_PAYLOAD : S_HUNT;
            end
            S_PAYLOAD: begin
                // Only pull a payload word when the output register is free
                // or is being emptied on this same edge.
                w_rd = ~r_out_vld | out_rdy;
                if (w_take && (r_remaining == LEN_W'(1))) w_next_state = S_CSUM;
            end
            S_CSUM: begin
                if (w_take) w_next_state = S_HUNT;
            end
            default: w_next_state = S_HUNT;
        endcase
        if (rst) w_rd = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_HUNT;
            r_remaining <= '0;
            r_sum       <= 16'd0;
            r_first     <= 1'b0;
            r_out_data  <= 16'd0;
            r_out_vld   <= 1'b0;
            r_out_sop   <= 1'b0;
            r_out_eop   <= 1'b0;
            r_frame_ok  <= 1'b0;
            r_csum_err  <= 1'b0;
            r_len_err   <= 1'b0;
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            r_state    <= w_next_state;
            r_frame_ok <= 1'b0;
            r_csum_err <= 1'b0;
            r_len_err  <= 1'b0;

            case (r_state)
                S_LEN: begin
                    if (w_take) begin
                        if (w_len_ok) begin
                            r_remaining <= in_data[LEN_W-1:0];
                            r_sum       <= 16'd0;
                            r_first     <= 1'b1;
                        end else begin
                            r_len_err <= 1'b1;
                            r_err_cnt <= r_err_cnt + CNT_W'(1);
                        end
                    end
                end
                S_PAYLOAD: begin
                    if (w_take) begin
                        r_sum       <= r_sum + in_data;
                        r_remaining <= r_remaining - LEN_W'(1);
                        r_first     <= 1'b0;
                    end
                end
                S_CSUM: begin
                    if (w_take) begin
                        if (in_data == r_sum) begin
                            r_frame_ok  <= 1'b1;
                            r_frame_cnt <= r_frame_cnt + CNT_W'(1);
                        end else begin
                            r_csum_err <= 1'b1;
                            r_err_cnt  <= r_err_cnt + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase

            // Single output register: a load wins over a drain, so a transfer
            // and a load on the same edge leave out_vld set with the new word.
            if (w_load) begin
                r_out_vld  <= 1'b1;
                r_out_data <= in_data;
                r_out_sop  <= r_first;
                r_out_eop  <= (r_remaining == LEN_W'(1));
            end else if (r_out_vld && out_rdy) begin
                r_out_vld <= 1'b0;
                r_out_sop <= 1'b0;
                r_out_eop <= 1'b0;
            end
        end
    end

    assign in_rd     = w_rd;
    assign out_data  = r_out_data;
    assign out_vld   = r_out_vld;
    assign out_sop   = r_out_sop;
    assign out_eop   = r_out_eop;
    assign frame_ok  = r_frame_ok;
    assign csum_err  = r_csum_err;
    assign len_err   = r_len_err;
    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_fifo_frame_parser_16.sv
// Bench for fifo_frame_parser_16. Input words are fed through the FIFO
// handshake; a monitor records every output transfer and pulse. Expectations
// come from a stream-level model that scans the consumed word list for
// sync/length/payload/checksum groups.

module tb_fifo_frame_parser_16;

    localparam logic [15:0] SYNC = 16'hEB90;
    localparam int          MAXL = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_vld;
    logic        in_rd;
    logic [15:0] out_data;
    logic        out_vld;
    logic        out_sop;
    logic        out_eop;
    logic        out_rdy;
    logic        frame_ok;
    logic        csum_err;
    logic        len_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;
    logic [1:0]  dbg_state;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] stim_q[$];
    logic [15:0] hist_q[$];
    logic [17:0] exp_q[$];
    logic [17:0] act_q[$];
    int ok_seen   = 0;
    int csum_seen = 0;
    int len_seen  = 0;
    int exp_ok;
    int exp_csum;
    int exp_len;

    fifo_frame_parser_16 dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_vld    (in_vld),
        .in_rd     (in_rd),
        .out_data  (out_data),
        .out_vld   (out_vld),
        .out_sop   (out_sop),
        .out_eop   (out_eop),
        .out_rdy   (out_rdy),
        .frame_ok  (frame_ok),
        .csum_err  (csum_err),
        .len_err   (len_err),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: simulation still running, expected to finish");
        $fatal(1, "timeout");
    end

    // Monitor: samples mid-cycle; a transfer seen here completes on the next edge.
    always @(negedge clk) begin
        if (rst) begin
            act_q.delete();
            ok_seen   = 0;
            csum_seen = 0;
            len_seen  = 0;
        end else begin
            if (out_vld && out_rdy) act_q.push_back({out_sop, out_eop, out_data});
            if (frame_ok) ok_seen++;
            if (csum_err) csum_seen++;
            if (len_err)  len_seen++;
        end
    end

    // ---------------- reference model ----------------
    // Scans the consumed stream: skip to a sync word, read a length, take that
    // many payload words, then compare the next word with their 16-bit sum.
    task automatic model_parse();
        int i;
        int len;
        int s;
        exp_q.delete();
        exp_ok = 0;
        exp_csum = 0;
        exp_len = 0;
        i = 0;
        while (i < hist_q.size()) begin
            if (hist_q[i] != SYNC) begin
                i++;
                continue;
            end
            i++;
            if (i >= hist_q.size()) break;
            len = int'(hist_q[i]);
            i++;
            if (len == 0 || len > MAXL) begin
                exp_len++;
                continue;
            end
            s = 0;
            for (int j = 0; j < len && (i + j) < hist_q.size(); j++) begin
                exp_q.push_back({(j == 0), (j == len - 1), hist_q[i + j]});
                s = (s + int'(hist_q[i + j])) % 65536;
            end
            i += len;
            if (i < hist_q.size()) begin
                if (int'(hist_q[i]) == s) exp_ok++;
                else exp_csum++;
                i++;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic reset_dut();
        @(posedge clk); #1;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        rst     = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        hist_q.delete();
    endtask

    // Presents stim_q word by word; returns at the mid-cycle point of the
    // cycle whose closing edge consumes the last word.
    task automatic feed(input bit rand_vld, input bit rand_rdy);
        bit taken;
        int guard;
        for (int k = 0; k < stim_q.size(); k++) begin
            taken = 1'b0;
            guard = 0;
            while (!taken) begin
                @(posedge clk); #1;
                in_vld  = rand_vld ? ($urandom_range(0, 3) != 0) : 1'b1;
                in_data = stim_q[k];
                out_rdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                taken = in_vld && in_rd;
                guard++;
                if (!taken && guard > 200) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL feed_timeout: word %0d not consumed in 200 cycles, expected consumption", k);
                    return;
                end
            end
            hist_q.push_back(stim_q[k]);
        end
    endtask

    task automatic cyc(input logic [15:0] d, input logic rdy, output bit taken);
        @(posedge clk); #1;
        in_vld  = 1'b1;
        in_data = d;
        out_rdy = rdy;
        @(negedge clk);
        taken = in_vld && in_rd;
        if (taken) hist_q.push_back(d);
    endtask

    task automatic drain();
        @(posedge clk); #1;
        in_vld  = 1'b0;
        out_rdy = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; in_vld = 1'b0; out_rdy = 1'b0; in_data = 16'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++; if (in_rd !== 1'b0) begin n_fail++; $display("FAIL reset_in_rd_gated: got %b, expected 0", in_rd); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL reset_out_vld: got %b, expected 0", out_vld); end
        n_checks++; if ({out_sop, out_eop} !== 2'b00) begin n_fail++; $display("FAIL reset_sop_eop: got %b, expected 00", {out_sop, out_eop}); end
        n_checks++; if ({frame_ok, csum_err, len_err} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b, expected 000", {frame_ok, csum_err, len_err}); end
        n_checks++; if (out_data !== 16'h0) begin n_fail++; $display("FAIL reset_out_data: got %h, expected 0000", out_data); end
        n_checks++; if (frame_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
        n_checks++; if (err_cnt !== 16'h0) begin n_fail++; $display("FAIL reset_err_cnt: got %0d, expected 0", err_cnt); end
        n_checks++; if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d, expected 0 (HUNT)", dbg_state); end
        n_checks++; if (in_rd !== 1'b1) begin n_fail++; $display("FAIL reset_in_rd_hunt: got %b, expected 1", in_rd); end
        hist_q.delete();
    endtask

    task automatic test_good_frame();
        reset_dut();
        stim_q = '{SYNC, 16'h0003, 16'h0001, 16'h0002, 16'h0003, 16'h0006};
        feed(1'b0, 1'b0);
        @(posedge clk); #1;
        in_vld = 1'b0;
        @(negedge clk);
        n_checks++; if (frame_ok !== 1'b1) begin n_fail++; $display("FAIL good_ok_timing: got %b, expected 1 one cycle after checksum", frame_ok); end
        n_checks++; if (out_vld !== 1'b0) begin n_fail++; $display("FAIL good_out_empty: got %b, expected 0", out_vld); end
        drain();
        model_parse();
        n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL good_words: got %0d, expected %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_checks++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL good_word%0d: got %h, expected %h", k, act_q[k], exp_q[k]); end
        end
        n_checks++; if (ok_seen != exp_ok) begin n_fail++; $display("FAIL good_ok_pulses: got %0d, expected %0d", ok_seen, exp_ok); end
        n_checks++; if (csum_seen + len_seen != exp_csum + exp_len) begin n_fail++; $display("FAIL good_err_pulses: got %0d, expected %0d", csum_seen + len_seen, exp_csum + exp_len); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL good_frame_cnt: got %0d, expected 1", frame_cnt); end
    endtask

    task automatic test_csum();
        reset_dut();
        stim_q = '{SYNC, 16'h0002, 16'hFFFF, 16'h0002, 16'h0001,
                   SYNC, 16'h0002, 16'hFFFF, 16'h0002, 16'h0002};
        feed(1'b0, 1'b0);
        drain();
        model_parse();
        n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL csum_words: got %0d, expected %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_checks++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL csum_word%0d: got %h, expected %h", k, act_q[k], exp_q[k]); end
        end
        n_checks++; if (ok_seen != exp_ok) begin n_fail++; $display("FAIL csum_ok_pulses: got %0d, expected %0d", ok_seen, exp_ok); end
        n_checks++; if (csum_seen != exp_csum) begin n_fail++; $display("FAIL csum_err_pulses: got %0d, expected %0d", csum_seen, exp_csum); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL csum_frame_cnt: got %0d, expected 1", frame_cnt); end
        n_checks++; if (err_cnt !== 16'd1) begin n_fail++; $display("FAIL csum_err_cnt: got %0d, expected 1", err_cnt); end
    endtask

    task automatic test_len_err();
        logic [15:0] w;
        int s;
        reset_dut();
        stim_q = '{SYNC, 16'h0000, SYNC, 16'h0401, SYNC, 16'h0001, 16'h0005, 16'h0005,
                   SYNC, 16'h0400};
        s = 0;
        for (int k = 0; k < MAXL; k++) begin
            w = 16'($urandom);
            stim_q.push_back(w);
            s = (s + int'(w)) % 65536;
        end
        stim_q.push_back(16'(s));
        feed(1'b0, 1'b0);
        drain();
        model_parse();
        n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL len_words: got %0d, expected %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_checks++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL len_word%0d: got %h, expected %h", k, act_q[k], exp_q[k]); end
        end
        n_checks++; if (len_seen != exp_len) begin n_fail++; $display("FAIL len_err_pulses: got %0d, expected %0d", len_seen, exp_len); end
        n_checks++; if (ok_seen != exp_ok) begin n_fail++; $display("FAIL len_ok_pulses: got %0d, expected %0d", ok_seen, exp_ok); end
        n_checks++; if (err_cnt !== 16'd2) begin n_fail++; $display("FAIL len_err_cnt: got %0d, expected 2", err_cnt); end
        n_checks++; if (frame_cnt !== 16'd2) begin n_fail++; $display("FAIL len_frame_cnt: got %0d, expected 2", frame_cnt); end
    endtask

    task automatic test_backpressure();
        logic [15:0] w0, w1, w2, w3;
        bit taken;
        reset_dut();
        w0 = 16'($urandom); w1 = 16'($urandom); w2 = 16'($urandom); w3 = 16'($urandom);
        stim_q = '{16'h1234, 16'h5678, SYNC, 16'h0004};
        feed(1'b0, 1'b0);
        cyc(w0, 1'b1, taken);
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL bp_first_take: got %b, expected 1", taken); end
        cyc(w1, 1'b0, taken);
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL bp_stall1_in_rd: got %b, expected 0", taken); end
        n_checks++; if ({out_vld, out_sop, out_data} !== {2'b11, w0}) begin n_fail++; $display("FAIL bp_stall1_out: got %b%b %h, expected 11 %h", out_vld, out_sop, out_data, w0); end
        cyc(w1, 1'b0, taken);
        n_checks++; if (taken !== 1'b0) begin n_fail++; $display("FAIL bp_stall2_in_rd: got %b, expected 0", taken); end
        n_checks++; if (out_data !== w0) begin n_fail++; $display("FAIL bp_stall2_hold: got %h, expected %h", out_data, w0); end
        cyc(w1, 1'b1, taken);
        n_checks++; if (taken !== 1'b1) begin n_fail++; $display("FAIL bp_resume_take: got %b, expected 1", taken); end
        stim_q = '{w2, w3, 16'(int'(w0) + int'(w1) + int'(w2) + int'(w3))};
        feed(1'b0, 1'b0);
        drain();
        model_parse();
        n_checks++; if (act_q.size() != 4) begin n_fail++; $display("FAIL bp_words: got %0d, expected 4", act_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_checks++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_word%0d: got %h, expected %h", k, act_q[k], exp_q[k]); end
        end
        n_checks++; if (ok_seen != 1) begin n_fail++; $display("FAIL bp_ok_pulses: got %0d, expected 1", ok_seen); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL bp_frame_cnt: got %0d, expected 1", frame_cnt); end
    endtask

    task automatic test_single_word();
        reset_dut();
        stim_q = '{SYNC, 16'h0001, 16'hABCD, 16'hABCD};
        feed(1'b0, 1'b0);
        drain();
        n_checks++; if (act_q.size() != 1) begin n_fail++; $display("FAIL single_words: got %0d, expected 1", act_q.size()); end
        n_checks++; if (act_q[0] !== {2'b11, 16'hABCD}) begin n_fail++; $display("FAIL single_word: got %h, expected %h", act_q[0], {2'b11, 16'hABCD}); end
        n_checks++; if (ok_seen != 1) begin n_fail++; $display("FAIL single_ok_pulses: got %0d, expected 1", ok_seen); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL single_frame_cnt: got %0d, expected 1", frame_cnt); end
    endtask

    task automatic test_mid_reset();
        logic [15:0] x, y;
        reset_dut();
        stim_q = '{SYNC, 16'h0005, 16'h1111, 16'h2222};
        feed(1'b0, 1'b0);
        @(posedge clk); #1;
        in_vld  = 1'b1;
        in_data = 16'h3333;
        rst     = 1'b1;
        @(negedge clk);
        n_checks++; if (in_rd !== 1'b0) begin n_fail++; $display("FAIL mid_rst_in_rd: got %b, expected 0", in_rd); end
        @(posedge clk); #1;
        rst    = 1'b0;
        in_vld = 1'b0;
        hist_q.delete();
        @(negedge clk);
        n_checks++; if ({out_vld, out_sop, out_eop} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_flags: got %b, expected 000", {out_vld, out_sop, out_eop}); end
        n_checks++; if ({frame_ok, csum_err, len_err} !== 3'b000) begin n_fail++; $display("FAIL mid_rst_pulses: got %b, expected 000", {frame_ok, csum_err, len_err}); end
        n_checks++; if ({out_data, frame_cnt, err_cnt} !== 48'h0) begin n_fail++; $display("FAIL mid_rst_regs: got %h, expected 0", {out_data, frame_cnt, err_cnt}); end
        x = 16'($urandom); y = 16'($urandom);
        stim_q = '{SYNC, 16'h0002, x, y, 16'(int'(x) + int'(y))};
        feed(1'b0, 1'b0);
        drain();
        model_parse();
        n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL mid_rst_words: got %0d, expected %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_checks++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL mid_rst_word%0d: got %h, expected %h", k, act_q[k], exp_q[k]); end
        end
        n_checks++; if (csum_seen + len_seen != 0) begin n_fail++; $display("FAIL mid_rst_err_pulses: got %0d, expected 0", csum_seen + len_seen); end
        n_checks++; if (frame_cnt !== 16'd1) begin n_fail++; $display("FAIL mid_rst_frame_cnt: got %0d, expected 1", frame_cnt); end
    endtask

    task automatic test_random();
        logic [15:0] w;
        int kind;
        int len;
        int s;
        reset_dut();
        stim_q.delete();
        for (int f = 0; f < 40; f++) begin
            repeat ($urandom_range(0, 2)) begin
                w = 16'($urandom);
                if (w == SYNC) w = w ^ 16'h0001;
                stim_q.push_back(w);
            end
            kind = $urandom_range(0, 9);
            stim_q.push_back(SYNC);
            if (kind == 9) begin
                stim_q.push_back($urandom_range(0, 1) ? 16'h0000 : 16'($urandom_range(MAXL + 1, 65535)));
            end else begin
                len = $urandom_range(1, 12);
                stim_q.push_back(16'(len));
                s = 0;
                for (int j = 0; j < len; j++) begin
                    w = ($urandom_range(0, 7) == 0) ? SYNC : 16'($urandom);
                    stim_q.push_back(w);
                    s = (s + int'(w)) % 65536;
                end
                if (kind >= 7) s = (s + $urandom_range(1, 65535)) % 65536;
                stim_q.push_back(16'(s));
            end
        end
        feed(1'b1, 1'b1);
        drain();
        model_parse();
        n_checks++; if (act_q.size() != exp_q.size()) begin n_fail++; $display("FAIL rand_words: got %0d, expected %0d", act_q.size(), exp_q.size()); end
        for (int k = 0; k < exp_q.size() && k < act_q.size(); k++) begin
            n_checks++; if (act_q[k] !== exp_q[k]) begin n_fail++; $display("FAIL rand_word%0d: got %h, expected %h", k, act_q[k], exp_q[k]); end
        end
        n_checks++; if (ok_seen != exp_ok) begin n_fail++; $display("FAIL rand_ok_pulses: got %0d, expected %0d", ok_seen, exp_ok); end
        n_checks++; if (csum_seen != exp_csum) begin n_fail++; $display("FAIL rand_csum_pulses: got %0d, expected %0d", csum_seen, exp_csum); end
        n_checks++; if (len_seen != exp_len) begin n_fail++; $display("FAIL rand_len_pulses: got %0d, expected %0d", len_seen, exp_len); end
        n_checks++; if (frame_cnt !== 16'(exp_ok)) begin n_fail++; $display("FAIL rand_frame_cnt: got %0d, expected %0d", frame_cnt, exp_ok); end
        n_checks++; if (err_cnt !== 16'(exp_csum + exp_len)) begin n_fail++; $display("FAIL rand_err_cnt: got %0d, expected %0d", err_cnt, exp_csum + exp_len); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_good_frame();
        test_csum();
        test_len_err();
        test_backpressure();
        test_single_word();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
